// File: rtl/rename_stage.sv
// rename_stage: register-rename stage between decode and dispatch.
//
// Each accepted group of WAYS instructions has its architectural sources
// translated through the rename map (with bypass from older ways of the same
// group), and every writing way with rd != 0 is given a fresh physical tag
// from a circular free list. The first jump of a group snapshots the map and
// the free-list read pointer so that a misprediction can roll both back.
// Retired tags are written back into the free list.
//
// Ports:
//   clock, reset_n                        clock, async active-low reset
//   in_valid / in_ready                   group handshake from decode
//   in_known, in_writes, in_jumps         per-way flags
//   in_rs1, in_rs2, in_rd                 per-way architectural registers
//   out_valid / out_ready                 registered group to dispatch
//   out_ps1, out_ps2, out_pd, out_old_pd  per-way physical tags
//   out_spec, out_jump_mask               per-way speculation / jump flags
//   retire_valid, retire_tag              tags returned to the free list
//   br_resolve, br_mispredict             checkpoint release / restore
//   free_count                            free-list occupancy
//   err_multi_jump                        sticky: group held more than one jump
module rename_stage #(
  parameter int WAYS      = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_TAGS = 64,
  localparam int TAG_W    = $clog2(PHYS_TAGS),
  localparam int AREG_W   = $clog2(ARCH_REGS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WAYS-1:0]              in_known,
  input  logic [WAYS-1:0][AREG_W-1:0]  in_rs1,
  input  logic [WAYS-1:0][AREG_W-1:0]  in_rs2,
  input  logic [WAYS-1:0][AREG_W-1:0]  in_rd,
  input  logic [WAYS-1:0]              in_writes,
  input  logic [WAYS-1:0]              in_jumps,
  output logic [WAYS-1:0]              out_valid,
  input  logic                         out_ready,
  output logic [WAYS-1:0][TAG_W-1:0]   out_ps1,
  output logic [WAYS-1:0][TAG_W-1:0]   out_ps2,
  output logic [WAYS-1:0][TAG_W-1:0]   out_pd,
  output logic [WAYS-1:0][TAG_W-1:0]   out_old_pd,
  output logic [WAYS-1:0]              out_spec,
  output logic [WAYS-1:0]              out_jump_mask,
  input  logic [WAYS-1:0]              retire_valid,
  input  logic [WAYS-1:0][TAG_W-1:0]   retire_tag,
  input  logic                         br_resolve,
  input  logic                         br_mispredict,
  output logic [TAG_W:0]               free_count,
  output logic                         err_multi_jump
);

  localparam int DEPTH = PHYS_TAGS - ARCH_REGS;
  localparam int PTR_W = TAG_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Pointers run modulo 2*DEPTH so that full and empty are distinguishable.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(2*DEPTH-1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
    return IDX_W'((p >= ptr_t'(DEPTH)) ? p - ptr_t'(DEPTH) : p);
  endfunction

  tag_t map_reg       [ARCH_REGS];
  tag_t map_next      [ARCH_REGS];
  tag_t ckpt_map_reg  [ARCH_REGS];
  tag_t ckpt_map_next [ARCH_REGS];
  tag_t free_list     [DEPTH];

  ptr_t rptr_reg, wptr_reg, ckpt_rptr_reg;
  ptr_t rptr_next, wptr_next, ckpt_rptr_next, need;
  logic ckpt_active_reg;
  logic take_ckpt, multi_jump, accept, restore;

  logic [WAYS-1:0]             alloc, jump, wr_en, spec_next;
  logic [WAYS-1:0][IDX_W-1:0]  wr_idx;
  logic [WAYS-1:0][TAG_W-1:0]  ps1_next, ps2_next, pd_next, old_next;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign alloc[gi] = in_known[gi] && in_writes[gi] && (in_rd[gi] != '0);
    assign jump[gi]  = in_known[gi] && in_jumps[gi];
  end

  // Sequential walk over the ways: each way sees the map as already updated
  // by the older ways of the same group.
  always_comb begin
    map_next       = map_reg;
    ckpt_map_next  = map_reg;
    rptr_next      = rptr_reg;
    ckpt_rptr_next = rptr_reg;
    need           = '0;
    take_ckpt      = 1'b0;
    multi_jump     = 1'b0;
    ps1_next       = '0;
    ps2_next       = '0;
    pd_next        = '0;
    old_next       = '0;
    spec_next      = '0;
    for (int k = 0; k < WAYS; k++) begin
      ps1_next[k]  = (in_rs1[k] == '0) ? '0 : map_next[in_rs1[k]];
      ps2_next[k]  = (in_rs2[k] == '0) ? '0 : map_next[in_rs2[k]];
      // The jump way itself is not younger than its own checkpoint.
      spec_next[k] = ckpt_active_reg || take_ckpt;
      if (alloc[k]) begin
        pd_next[k]          = free_list[ptr_idx(rptr_next)];
        old_next[k]         = map_next[in_rd[k]];
        map_next[in_rd[k]]  = pd_next[k];
        rptr_next           = ptr_inc(rptr_next);
        need                = need + ptr_t'(1);
      end
      if (jump[k]) begin
        if (!take_ckpt) begin
          take_ckpt      = 1'b1;
          ckpt_map_next  = map_next;
          ckpt_rptr_next = rptr_next;
        end else begin
          multi_jump = 1'b1;
        end
      end
    end
  end

  // Retired tags land at consecutive write slots in way order; tag 0 is skipped.
  always_comb begin
    wptr_next = wptr_reg;
    wr_en     = '0;
    wr_idx    = '0;
    for (int k = 0; k < WAYS; k++) begin
      wr_en[k]  = retire_valid[k] && (retire_tag[k] != '0);
      wr_idx[k] = ptr_idx(wptr_next);
      if (wr_en[k]) begin
        wptr_next = ptr_inc(wptr_next);
      end
    end
  end

  assign free_count = (wptr_reg >= rptr_reg) ? (wptr_reg - rptr_reg)
                                             : (wptr_reg + ptr_t'(2*DEPTH) - rptr_reg);

  // Uses registered free_count, so same-cycle retires do not help this group.
  assign in_ready = !br_mispredict && ((out_valid == '0) || out_ready) &&
                    (free_count >= need) && !(ckpt_active_reg && (|in_jumps));
  assign accept   = in_valid && in_ready;
  assign restore  = br_mispredict && ckpt_active_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_reg[i]      <= tag_t'(i);
        ckpt_map_reg[i] <= tag_t'(i);
      end
      for (int i = 0; i < DEPTH; i++) begin
        free_list[i] <= tag_t'(ARCH_REGS + i);
      end
      rptr_reg        <= '0;
      wptr_reg        <= ptr_t'(DEPTH);
      ckpt_rptr_reg   <= '0;
      ckpt_active_reg <= 1'b0;
      err_multi_jump  <= 1'b0;
      out_valid       <= '0;
      out_ps1         <= '0;
      out_ps2         <= '0;
      out_pd          <= '0;
      out_old_pd      <= '0;
      out_spec        <= '0;
      out_jump_mask   <= '0;
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        if (wr_en[k]) begin
          free_list[wr_idx[k]] <= retire_tag[k];
        end
      end
      // wptr is never rolled back: retires during speculation stay freed.
      wptr_reg <= wptr_next;

      if (restore) begin
        map_reg  <= ckpt_map_reg;
        rptr_reg <= ckpt_rptr_reg;
      end else if (accept) begin
        map_reg  <= map_next;
        rptr_reg <= rptr_next;
      end

      if (accept && take_ckpt) begin
        ckpt_map_reg  <= ckpt_map_next;
        ckpt_rptr_reg <= ckpt_rptr_next;
      end

      if (restore) begin
        ckpt_active_reg <= 1'b0;
      end else if (accept && take_ckpt) begin
        ckpt_active_reg <= 1'b1;
      end else if (br_resolve) begin
        ckpt_active_reg <= 1'b0;
      end

      if (accept && multi_jump) begin
        err_multi_jump <= 1'b1;
      end

      if (accept) begin
        out_valid     <= in_known;
        out_ps1       <= ps1_next;
        out_ps2       <= ps2_next;
        out_pd        <= pd_next;
        out_old_pd    <= old_next;
        out_spec      <= spec_next;
        out_jump_mask <= in_jumps;
      end else if (out_ready) begin
        out_valid <= '0;
      end else if (restore) begin
        out_valid <= out_valid & ~out_spec;
      end
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Testbench for rename_stage (WAYS=2, ARCH_REGS=32, PHYS_TAGS=64).
// A behavioural reference (map array, ever-growing free-tag history with a
// read index) predicts each accepted group; predictions are queued when the
// group is driven and popped when the output register is sampled.
module tb_rename_stage;

  typedef struct packed {
    logic [1:0] known, writes, jumps;
    logic [1:0][4:0] rs1, rs2, rd;
  } grp_t;

  typedef struct packed {
    logic [1:0] valid;
    logic [1:0][5:0] ps1, ps2, pd, old;
    logic [1:0] spec, jm;
  } out_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_known = '0, in_writes = '0, in_jumps = '0;
  logic [1:0][4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [1:0] out_valid;
  logic out_ready = 1'b1;
  logic [1:0][5:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic [1:0] out_spec, out_jump_mask;
  logic [1:0] retire_valid = '0;
  logic [1:0][5:0] retire_tag = '0;
  logic br_resolve = 1'b0, br_mispredict = 1'b0;
  logic [6:0] free_count;
  logic err_multi_jump;

  always #5 clock = ~clock;

  rename_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_known(in_known), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_writes(in_writes), .in_jumps(in_jumps),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
    .out_spec(out_spec), .out_jump_mask(out_jump_mask),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict),
    .free_count(free_count), .err_multi_jump(err_multi_jump)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  int mmap[32];
  int ckpt_map[32];
  int hist[$];
  int rd_i = 0;
  int ckpt_rd = 0;
  bit ckpt_act = 1'b0;
  bit err_exp = 1'b0;
  out_t cur_exp = '0;
  out_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic grp_t mk(input logic [1:0] known, writes, jumps,
                              input int rd0, rd1, a0, a1, b0, b1);
    grp_t g;
    g.known = known; g.writes = writes; g.jumps = jumps;
    g.rd[0] = 5'(rd0);  g.rd[1] = 5'(rd1);
    g.rs1[0] = 5'(a0);  g.rs1[1] = 5'(a1);
    g.rs2[0] = 5'(b0);  g.rs2[1] = 5'(b1);
    return g;
  endfunction

  // Called at posedge+1; drives one cycle, predicts, checks after next edge.
  task automatic run_cycle(input grp_t g, input bit v, input logic [1:0] rv,
                           input logic [1:0][5:0] rt, input bit res, input bit mis,
                           input bit ordy);
    int need;
    bit rdy_exp, acc, mis_eff, found;
    out_t e;
    in_valid = v; in_known = g.known; in_writes = g.writes; in_jumps = g.jumps;
    in_rs1 = g.rs1; in_rs2 = g.rs2; in_rd = g.rd;
    retire_valid = rv; retire_tag = rt;
    br_resolve = res; br_mispredict = mis; out_ready = ordy;
    need = 0;
    for (int k = 0; k < 2; k++)
      if (g.known[k] && g.writes[k] && g.rd[k] != 0) need++;
    rdy_exp = !mis && (cur_exp.valid == 0 || ordy) && ((hist.size() - rd_i) >= need)
              && !(ckpt_act && (|g.jumps));
    #3;
    check_eq("in_ready", 32'(in_ready), 32'(rdy_exp));
    acc = v && rdy_exp;
    mis_eff = mis && ckpt_act;
    found = 1'b0;
    e = '0;
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        e.ps1[k] = (g.rs1[k] == 0) ? 6'd0 : 6'(mmap[g.rs1[k]]);
        e.ps2[k] = (g.rs2[k] == 0) ? 6'd0 : 6'(mmap[g.rs2[k]]);
        e.spec[k] = ckpt_act || found;
        if (g.known[k] && g.writes[k] && g.rd[k] != 0) begin
          e.pd[k] = 6'(hist[rd_i]);
          e.old[k] = 6'(mmap[g.rd[k]]);
          mmap[g.rd[k]] = hist[rd_i];
          rd_i++;
        end
        if (g.known[k] && g.jumps[k]) begin
          if (!found) begin
            found = 1'b1;
            ckpt_map = mmap;
            ckpt_rd = rd_i;
          end else begin
            err_exp = 1'b1;
          end
        end
      end
      e.valid = g.known;
      e.jm = g.jumps;
      sb_q.push_back(e);
    end
    if (mis_eff) begin
      mmap = ckpt_map;
      rd_i = ckpt_rd;
      ckpt_act = 1'b0;
    end else if (acc && found) begin
      ckpt_act = 1'b1;
    end else if (res) begin
      ckpt_act = 1'b0;
    end
    for (int k = 0; k < 2; k++)
      if (rv[k] && rt[k] != 0) hist.push_back(int'(rt[k]));
    if (!acc) begin
      if (ordy) cur_exp.valid = '0;
      else if (mis_eff) cur_exp.valid = cur_exp.valid & ~cur_exp.spec;
    end
    @(posedge clock);
    #1;
    if (acc) begin
      cur_exp = sb_q.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'(cur_exp.valid));
      check_eq("out_ps1", 32'(out_ps1), 32'(cur_exp.ps1));
      check_eq("out_ps2", 32'(out_ps2), 32'(cur_exp.ps2));
      check_eq("out_pd", 32'(out_pd), 32'(cur_exp.pd));
      check_eq("out_old_pd", 32'(out_old_pd), 32'(cur_exp.old));
      check_eq("out_spec", 32'(out_spec), 32'(cur_exp.spec));
      check_eq("out_jump_mask", 32'(out_jump_mask), 32'(cur_exp.jm));
    end else begin
      check_eq("out_valid_hold", 32'(out_valid), 32'(cur_exp.valid));
    end
    check_eq("free_count", 32'(free_count), 32'(hist.size() - rd_i));
    check_eq("err_multi_jump", 32'(err_multi_jump), 32'(err_exp));
    $display("[TB] cyc %0d acc=%0b valid=%b pd=%0d,%0d old=%0d,%0d spec=%b free=%0d",
             cyc, acc, out_valid, out_pd[0], out_pd[1], out_old_pd[0], out_old_pd[1],
             out_spec, free_count);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    grp_t idle, s, fj;
    for (int i = 0; i < 32; i++) mmap[i] = i;
    for (int i = 32; i < 64; i++) hist.push_back(i);
    idle = '0;

    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_pd", 32'(out_pd), 0);
    check_eq("rst_out_spec", 32'(out_spec), 0);
    check_eq("rst_free", 32'(free_count), 32);
    check_eq("rst_err", 32'(err_multi_jump), 0);
    check_eq("rst_ready", 32'(in_ready), 1);
    @(posedge clock); #1;

    // Basic allocation.
    run_cycle(mk(2'b11, 2'b11, 2'b00, 5, 6, 0, 0, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("g1_pd0", 32'(out_pd[0]), 32);
    check_eq("g1_pd1", 32'(out_pd[1]), 33);
    check_eq("g1_old0", 32'(out_old_pd[0]), 5);
    check_eq("g1_old1", 32'(out_old_pd[1]), 6);
    check_eq("g1_free", 32'(free_count), 30);

    // Intra-group bypass, then rd = 0 writes.
    run_cycle(mk(2'b11, 2'b01, 2'b00, 7, 0, 0, 7, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("bypass_ps1", 32'(out_ps1[1]), 34);
    run_cycle(mk(2'b11, 2'b11, 2'b00, 0, 0, 5, 6, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("x0_pd", 32'(out_pd), 0);

    // Drain the free list.
    for (int i = 0; i < 14; i++)
      run_cycle(mk(2'b11, 2'b11, 2'b00, 11 + i % 10, 21 + i % 10, i, 0, 0, i), 1, '0, '0, 0, 0, 1);
    run_cycle(mk(2'b11, 2'b01, 2'b00, 3, 0, 0, 0, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("drained_free", 32'(free_count), 0);

    // Stall on empty list; retire same cycle still stalls; then freed tags wrap.
    s = mk(2'b11, 2'b11, 2'b00, 1, 2, 0, 0, 0, 0);
    run_cycle(s, 1, '0, '0, 0, 0, 1);
    run_cycle(s, 1, 2'b11, {6'd6, 6'd5}, 0, 0, 1);
    run_cycle(s, 1, '0, '0, 0, 0, 1);
    check_eq("wrap_pd0", 32'(out_pd[0]), 5);
    check_eq("wrap_pd1", 32'(out_pd[1]), 6);

    run_cycle(idle, 0, 2'b11, {6'd35, 6'd7}, 0, 0, 1);
    run_cycle(idle, 0, 2'b11, {6'd37, 6'd36}, 0, 0, 1);

    // Checkpoint at way 0, speculative follow-on group, mispredict.
    run_cycle(mk(2'b11, 2'b10, 2'b01, 0, 9, 1, 0, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("ckpt_spec", 32'(out_spec), 32'h2);
    run_cycle(mk(2'b11, 2'b01, 2'b00, 10, 0, 0, 9, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("spec_group", 32'(out_spec), 32'h3);
    run_cycle(idle, 0, '0, '0, 0, 0, 0);
    run_cycle(idle, 0, '0, '0, 0, 1, 0);
    check_eq("mis_valid_clr", 32'(out_valid), 0);
    check_eq("mis_free", 32'(free_count), 4);
    run_cycle(mk(2'b11, 2'b00, 2'b00, 0, 0, 9, 10, 10, 0), 1, '0, '0, 0, 0, 1);
    check_eq("restored_map9", 32'(out_ps1[0]), 9);
    check_eq("restored_map10", 32'(out_ps1[1]), 10);

    // Mispredict without a checkpoint: no accept, nothing restored.
    run_cycle(mk(2'b11, 2'b01, 2'b00, 4, 0, 0, 0, 0, 0), 1, '0, '0, 0, 1, 1);

    // Resolve together with a new jump group: stalled one cycle.
    fj = mk(2'b11, 2'b01, 2'b01, 4, 0, 0, 0, 0, 0);
    run_cycle(fj, 1, '0, '0, 0, 0, 1);
    run_cycle(fj, 1, '0, '0, 1, 0, 1);
    check_eq("resolve_stall", 32'(out_valid), 0);
    run_cycle(fj, 1, '0, '0, 0, 0, 1);
    check_eq("new_ckpt_spec", 32'(out_spec), 32'h2);
    run_cycle(idle, 0, '0, '0, 1, 0, 1);

    // Two jumps in one group.
    run_cycle(mk(2'b11, 2'b10, 2'b11, 0, 12, 0, 0, 0, 0), 1, '0, '0, 0, 0, 1);
    check_eq("multi_err", 32'(err_multi_jump), 1);
    check_eq("multi_spec", 32'(out_spec), 32'h2);
    run_cycle(idle, 0, '0, '0, 0, 1, 1);

    // Reset mid-operation.
    run_cycle(mk(2'b11, 2'b11, 2'b00, 13, 14, 0, 0, 0, 0), 1, '0, '0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 0);
    check_eq("midrst_free", 32'(free_count), 32);
    check_eq("midrst_err", 32'(err_multi_jump), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
# rename_stage

Parametrised register-rename stage between decode and dispatch. Each cycle it accepts a group of WAYS decoded instructions and maps architectural sources to physical tags. It allocates fresh physical tags for destinations from a circular free list and resolves intra-group dependencies. It also takes a single map/free-list checkpoint at the first jump, so a mispredicted branch can be restored. Tags are returned to the free list on retire.

## Interface
- WAYS, 2, instructions per group (1..4)
- ARCH_REGS, 32, architectural registers; x0 is never renamed
- PHYS_TAGS, 64, physical tags; TAG_W = $clog2(PHYS_TAGS), AREG_W = $clog2(ARCH_REGS)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  group present
- in_ready  out  1  group accepted this edge when in_valid && in_ready
- in_known  in  WAYS  per-way instruction valid (decoded, not UNKNOWN)
- in_rs1, in_rs2, in_rd  in  WAYS×AREG_W  architectural registers
- in_writes, in_jumps  in  WAYS  per-way flags
- out_valid  out  WAYS  per-way renamed instruction valid
- out_ready  in  1  dispatch consumes output register
- out_ps1, out_ps2, out_pd, out_old_pd  out  WAYS×TAG_W  source tags, new destination tag, previous mapping of rd (freed at retire)
- out_spec  out  WAYS  way is younger than the active checkpoint
- out_jump_mask  out  WAYS  registered in_jumps of accepted ways
- retire_valid  in  WAYS  free one tag per set bit
- retire_tag  in  WAYS×TAG_W  tags to free
- br_resolve  in  1  outstanding jump resolved correctly; drop checkpoint
- br_mispredict  in  1  outstanding jump mispredicted; restore checkpoint
- free_count  out  TAG_W+1  free-list occupancy
- err_multi_jump  out  1  sticky; a group had more than one jump

## Operation
- Reset values:
  - map[i] = i.
  - Free list holds ARCH_REGS..PHYS_TAGS-1 in ascending order.
  - rptr = 0, wptr = PHYS_TAGS-ARCH_REGS. Pointers are TAG_W+1 bits wide and wrap modulo 2×depth, with depth = PHYS_TAGS-ARCH_REGS.
  - free_count = depth.
  - All out_* = 0. err_multi_jump = 0. ckpt_active = 0.
- Way k needs an allocation when in_known[k] && in_writes[k] && in_rd[k] != 0. Let need = the number of such ways.
- in_ready = !br_mispredict && (out_valid == 0 || out_ready) && free_count >= need && !(ckpt_active && |in_jumps).
- On accept, ways are processed in order 0..WAYS-1:
  - Sources read the map as updated by all older ways in the same group (intra-group bypass).
  - Register 0 always yields tag 0.
  - Allocating ways take consecutive free entries from rptr and update map[rd]. out_old_pd is the mapping before the update.
  - Non-allocating ways output out_pd = 0 and out_old_pd = 0.
  - out_valid[k] = in_known[k].
- Checkpoint:
  - The lowest way j with in_known[j] && in_jumps[j] saves the map state after way j, and rptr after way j's allocation. ckpt_active is then set.
  - Ways k > j get out_spec = 1.
  - While ckpt_active, every accepted way gets out_spec = 1.
  - A second jump in the group sets err_multi_jump. That jump takes no checkpoint and is handled as a normal instruction.
- br_resolve: clear ckpt_active. Entries still held in the output register keep their out_spec value.
- br_mispredict:
  - Map and rptr are restored from the checkpoint; ckpt_active is cleared.
  - Output-register ways with out_spec = 1 get their out_valid cleared.
  - In that cycle in_ready = 0 and no accept occurs.
  - Ignored when ckpt_active = 0.
- Retire: each set retire_valid bit writes retire_tag to wptr in way order, and wptr advances. Retiring tag 0 is ignored.
- free_count = wptr − rptr.

## Timing
- One-cycle latency: a group accepted at edge N appears on out_* after edge N.
- The output register holds its value while out_valid != 0 && !out_ready.
- Map, pointer and checkpoint updates take effect at the accept edge. The next group sees them.
- Retire and accept in the same cycle:
  - Both apply.
  - Accept eligibility uses free_count before the retire frees land.
- Events on the checkpoint:
  - br_resolve and br_mispredict together: mispredict wins.
  - br_resolve and accept of a jump group in the same cycle: the jump group is stalled, because in_ready uses the registered ckpt_active. It is accepted the next cycle.
  - Retires arriving between checkpoint and mispredict are preserved, since wptr is not restored.
- Reset asserted mid-operation immediately returns all state to its reset value and drops out_valid.

## Test plan
- Reset, then accept group rd = {5, 6} with writes = 11 → out_pd = {32, 33}, out_old_pd = {5, 6}, free_count 32→30.
- Group way0 rd = 7, way1 rs1 = 7 → way1 out_ps1 equals way0 out_pd. Group rd = {0, 0} with writes = 11 → no allocation, out_pd = 0.
- Allocate 32 tags with no retire → in_ready = 0 when need > free_count. Then retire two tags → the group is accepted next cycle and the freed tags reappear after wraparound.
- Group way0 jumps, way1 rd = 9 → out_spec = {0, 1}.
  - Next group rd = 10 is speculative.
  - br_mispredict → map[9] and map[10] revert, free_count recovers 2, speculative out_valid bits clear.
- With ckpt_active, present a jump group together with br_resolve → stalled one cycle, then accepted with a new checkpoint.
- Group in_jumps = 11 → err_multi_jump = 1; checkpoint taken at way 0 only.
